// File: rtl/soc_system_clkdiv_pkg.sv
// Shared types and defaults for the system clock-divider bank.
// Lock-state encoding, default divider settings and the select-width helper.
package soc_system_clkdiv_pkg;

    typedef enum logic [0:0] {
        LOCKING = 1'b0,
        LOCKED  = 1'b1
    } lock_state_e;

    localparam int unsigned DEF_DIV     = 2;
    localparam int unsigned LOCK_CYCLES = 16;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_system_clkdiv_chan.sv
// One divider channel: active ratio, pending ratio/phase and phase counter.
// Outputs are registered from the counter value of the previous cycle.
module soc_system_clkdiv_chan
    import soc_system_clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DEF_DIV = soc_system_clkdiv_pkg::DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [CNT_W-1:0] div,
    input  logic [CNT_W-1:0] phase,
    output logic             outclk,
    output logic             outclk_en,
    output logic             pending
);

    logic [CNT_W-1:0] d_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] pdiv_q;
    logic [CNT_W-1:0] pphase_q;
    logic             pend_q;

    logic             d_zero;
    logic             tc;
    logic [CNT_W-1:0] high_len;
    logic             apply;
    logic [CNT_W-1:0] apply_div;
    logic [CNT_W-1:0] apply_phase;
    logic [CNT_W-1:0] cnt_d;

    assign d_zero   = (d_q == '0);
    assign tc       = !d_zero && (cnt_q == d_q - CNT_W'(1));
    assign high_len = d_q - (d_q >> 1);
    assign pending  = pend_q;

    // A write landing on the terminal count bypasses the pending registers;
    // a disabled channel applies its pending config on the following edge.
    always_comb begin
        apply       = 1'b0;
        apply_div   = pdiv_q;
        apply_phase = pphase_q;
        if (tc && we) begin
            apply       = 1'b1;
            apply_div   = div;
            apply_phase = phase;
        end else if (tc && pend_q) begin
            apply = 1'b1;
        end else if (d_zero && pend_q && !we) begin
            apply = 1'b1;
        end
    end

    always_comb begin
        cnt_d = '0;
        if (apply) begin
            cnt_d = (apply_phase < apply_div) ? apply_phase : '0;
        end else if (!d_zero && !tc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q       <= CNT_W'(DEF_DIV);
            cnt_q     <= '0;
            pdiv_q    <= '0;
            pphase_q  <= '0;
            pend_q    <= 1'b0;
            outclk    <= 1'b0;
            outclk_en <= 1'b0;
        end else begin
            outclk_en <= tc;
            outclk    <= !d_zero && (cnt_q < high_len);
            cnt_q     <= cnt_d;
            if (apply) begin
                d_q <= apply_div;
            end
            if (we && !tc) begin
                pdiv_q   <= div;
                pphase_q <= phase;
                pend_q   <= 1'b1;
            end else if (apply) begin
                pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/soc_system_clkdiv_bank.sv
// Bank of programmable clock dividers sharing one reference clock,
// with a lock indicator that waits for a quiet period after reconfiguration.
module soc_system_clkdiv_bank
    import soc_system_clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CLOCKS  = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEF_DIV     = soc_system_clkdiv_pkg::DEF_DIV,
    parameter int unsigned LOCK_CYCLES = soc_system_clkdiv_pkg::LOCK_CYCLES
) (
    input  logic                                 refclk,
    input  logic                                 rst,
    input  logic                                 cfg_we,
    input  logic [sel_width(NUM_CLOCKS)-1:0]     cfg_sel,
    input  logic [CNT_W-1:0]                     cfg_div,
    input  logic [CNT_W-1:0]                     cfg_phase,
    output logic [NUM_CLOCKS-1:0]                outclk,
    output logic [NUM_CLOCKS-1:0]                outclk_en,
    output logic                                 locked
);

    localparam int unsigned SEL_W = sel_width(NUM_CLOCKS);
    localparam int unsigned LCW   = $clog2(LOCK_CYCLES + 1);

    logic                  wr_ok;
    logic [NUM_CLOCKS-1:0] chan_we;
    logic [NUM_CLOCKS-1:0] chan_pend;
    logic                  any_pend;

    lock_state_e           state_q;
    lock_state_e           state_d;
    logic [LCW-1:0]        lock_cnt_q;
    logic [LCW-1:0]        lock_cnt_d;

    assign wr_ok    = cfg_we && (32'(cfg_sel) < NUM_CLOCKS);
    assign any_pend = |chan_pend;

    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
        assign chan_we[g] = wr_ok && (cfg_sel == SEL_W'(g));

        soc_system_clkdiv_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk       (refclk),
            .rst       (rst),
            .we        (chan_we[g]),
            .div       (cfg_div),
            .phase     (cfg_phase),
            .outclk    (outclk[g]),
            .outclk_en (outclk_en[g]),
            .pending   (chan_pend[g])
        );
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= LOCKING;
            lock_cnt_q <= '0;
            locked     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            locked     <= (state_q == LOCKED);
        end
    end

    // Counter freezes while any channel still holds an unapplied config.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        if (wr_ok) begin
            state_d    = LOCKING;
            lock_cnt_d = '0;
        end else begin
            case (state_q)
                LOCKING: begin
                    if (!any_pend) begin
                        lock_cnt_d = lock_cnt_q + LCW'(1);
                        if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED:  state_d = LOCKED;
                default: state_d = LOCKING;
            endcase
        end
    end

endmodule

// File: doc/soc_system_clkdiv_bank.md
SOC_SYSTEM_CLKDIV_BANK -- requirements
Module: soc_system_clkdiv_bank

Interface
REQ-001 SHALL have parameter NUM_CLOCKS, default 2, number of derived clock channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16, divider/phase counter width.
REQ-003 SHALL have parameter DEF_DIV, default 2, divide ratio loaded into every channel at reset.
REQ-004 SHALL have parameter LOCK_CYCLES, default 16, quiet cycles required before locked asserts (>=1).
REQ-005 SHALL have port refclk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port cfg_we  input  1  configuration write strobe, one write per asserted cycle.
REQ-008 SHALL have port cfg_sel  input  max(1,clog2(NUM_CLOCKS))  target channel index.
REQ-009 SHALL have port cfg_div  input  CNT_W  new divide ratio; 0 = channel disabled.
REQ-010 SHALL have port cfg_phase  input  CNT_W  counter start value applied with the new ratio.
REQ-011 SHALL have port outclk  output  NUM_CLOCKS  divided clocks, registered.
REQ-012 SHALL have port outclk_en  output  NUM_CLOCKS  one-refclk-cycle enable pulses, registered.
REQ-013 SHALL have port locked  output  1  all channels stable under current configuration.

Function
REQ-014 Each channel SHALL hold active ratio D, pending ratio/phase, pending flag, and counter cnt running 0..D-1, wrapping to 0.
REQ-015 outclk_en[i] SHALL be 1 in the cycle after cnt==D-1 (terminal count); D=1 gives constant 1.
REQ-016 outclk[i] SHALL be 1 while cnt < D - floor(D/2) (high ceil(D/2), low floor(D/2) cycles); D=1 gives constant 1.
REQ-017 D=0 SHALL force outclk[i]=0, outclk_en[i]=0, cnt held 0.
REQ-018 cfg_we with cfg_sel < NUM_CLOCKS SHALL latch cfg_div/cfg_phase into that channel's pending registers and set pending; cfg_sel >= NUM_CLOCKS SHALL be ignored entirely (no lock drop).
REQ-019 Pending config SHALL be applied at the channel's next terminal count (glitch-free), or next cycle if active D is 0; on apply cnt loads cfg_phase if cfg_phase < new D, else 0.
REQ-020 Write coinciding with terminal count SHALL apply in that same edge; back-to-back writes to one channel before apply: last wins.
REQ-021 Lock FSM SHALL have states LOCKING and LOCKED with a lock counter.
REQ-022 LOCKING: counter increments each cycle with no accepted write and no pending flag set; reaching LOCK_CYCLES -> LOCKED.
REQ-023 Any accepted write SHALL clear the lock counter and force LOCKING; LOCKED -> LOCKING on the edge capturing the write, so locked deasserts the next cycle.
REQ-024 locked SHALL equal (state==LOCKED), registered.

Reset
REQ-025 rst SHALL set every D=DEF_DIV, pending=0, cnt=0, outclk=0, outclk_en=0, lock counter=0, state=LOCKING, locked=0.
REQ-026 rst asserted mid-operation SHALL override any simultaneous cfg_we; pending writes are discarded.
REQ-027 After rst release with defaults, first outclk_en pulse SHALL occur DEF_DIV cycles later; locked SHALL assert LOCK_CYCLES+1 cycles later.

Structure
REQ-028 Package soc_system_clkdiv_pkg SHALL hold lock-state enum and default constants (DEF_DIV, LOCK_CYCLES).
REQ-029 Per-channel counter/pending logic SHALL be sub-module soc_system_clkdiv_chan, instantiated NUM_CLOCKS times by generate; lock FSM stays in top.

Verification
REQ-030 Reset release, defaults -> outclk[0..1] toggle every cycle pair (period 2), outclk_en pulse every 2nd cycle, locked high at cycle 17.
REQ-031 Write ch1 div=5 phase=0 while LOCKED -> locked low next cycle; ch1 switches at its terminal count to high 3/low 2, pulse every 5 cycles; locked back after 16 quiet cycles.
REQ-032 Write ch0 div=4 phase=2 -> after apply, first outclk_en[0] 2 cycles later; phase=7 with div=4 -> cnt loads 0.
REQ-033 Write ch0 div=0 -> outclk[0], outclk_en[0] stay 0; then div=3 -> applied next cycle, period 3.
REQ-034 Writes at cycles 5 and 12 of locking -> locked asserts only 16 cycles after second write; cfg_sel=3 with NUM_CLOCKS=2 -> no change, locked unaffected.
REQ-035 rst pulsed mid-pattern with cfg_we same cycle -> all outputs 0, D=DEF_DIV, write discarded.
